// File: rtl/eeg_xram_pkg.sv
// Shared types for the XRAM read agent: FSM states and credit-counter sizing.
package eeg_xram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } xr_state_e;

  // One extra bit so the counter can hold DEPTH itself.
  function automatic int cred_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eeg_xram_rd_fifo.sv
// Return buffer: synchronous FIFO with full/empty flags and same-cycle push/pop.
module eeg_xram_rd_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]               wp, rp;
  logic [DEPTH-1:0][W-1:0]   mem;
  logic                      do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdat    = mem[rp[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[PW-1:0]] <= wdat;
  end

endmodule

// File: rtl/eeg_xram_rd_agent.sv
// XRAM read initiator: burst command -> address stream, returned data -> output stream.
module eeg_xram_rd_agent
  import eeg_xram_pkg::*;
#(
  parameter int XRAM_ADD_AW = 12,
  parameter int XRAM_DAT_DW = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CMD_VLD,
  output logic                   CMD_RDY,
  input  logic [XRAM_ADD_AW-1:0] CMD_ADD,
  input  logic [XRAM_ADD_AW-1:0] CMD_STP,
  input  logic [XRAM_ADD_AW-1:0] CMD_LEN,
  output logic                   XRAM_ADD_VLD,
  output logic                   XRAM_ADD_LST,
  input  logic                   XRAM_ADD_RDY,
  output logic [XRAM_ADD_AW-1:0] XRAM_ADD_ADD,
  input  logic                   XRAM_DAT_VLD,
  input  logic                   XRAM_DAT_LST,
  output logic                   XRAM_DAT_RDY,
  input  logic [XRAM_DAT_DW-1:0] XRAM_DAT_DAT,
  output logic                   OUT_VLD,
  input  logic                   OUT_RDY,
  output logic                   OUT_LST,
  output logic [XRAM_DAT_DW-1:0] OUT_DAT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);
  localparam int AW = XRAM_ADD_AW;
  localparam int DW = XRAM_DAT_DW;
  localparam int CW = cred_w(FIFO_DEPTH);

  xr_state_e     state;
  logic [AW-1:0] addr, stp, len, rem, rcnt;
  logic [CW-1:0] cred;
  logic          cmd_rdy, busy, err;
  logic          add_hs, out_hs, exp_lst, f_full, f_empty;
  logic [DW:0]   f_rdat;

  assign CMD_RDY      = cmd_rdy;
  assign BUSY         = busy;
  assign ERR          = err;
  assign XRAM_DAT_RDY = 1'b1;

  // Credits bound outstanding reads to the buffer depth, so returns never overflow.
  assign XRAM_ADD_VLD = (state == ISSUE) && (cred < CW'(FIFO_DEPTH));
  assign XRAM_ADD_LST = (state == ISSUE) && (rem == '0);
  assign XRAM_ADD_ADD = addr;
  assign add_hs       = XRAM_ADD_VLD & XRAM_ADD_RDY;

  assign OUT_VLD = ~f_empty;
  assign OUT_LST = ~f_empty & f_rdat[DW];
  assign OUT_DAT = f_empty ? '0 : f_rdat[DW-1:0];
  assign out_hs  = OUT_VLD & OUT_RDY;
  assign DONE    = out_hs & OUT_LST & (state == DRAIN);

  // The last marker comes from our own beat count; the responder's flag is only checked.
  assign exp_lst = (rcnt == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_rdy <= 1'b1;
      busy    <= 1'b0;
      addr    <= '0;
      stp     <= '0;
      len     <= '0;
      rem     <= '0;
    end else begin
      case (state)
        IDLE: if (CMD_VLD) begin
          state   <= ISSUE;
          cmd_rdy <= 1'b0;
          busy    <= 1'b1;
          addr    <= CMD_ADD;
          stp     <= CMD_STP;
          len     <= CMD_LEN;
          rem     <= CMD_LEN;
        end
        ISSUE: if (add_hs) begin
          addr <= addr + stp;
          rem  <= rem - 1'b1;
          if (rem == '0) state <= DRAIN;
        end
        DRAIN: if (DONE) begin
          state   <= IDLE;
          cmd_rdy <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred <= '0;
      rcnt <= '0;
      err  <= 1'b0;
    end else begin
      case ({add_hs, out_hs})
        2'b10:   cred <= cred + CW'(1);
        2'b01:   cred <= cred - CW'(1);
        default: cred <= cred;
      endcase
      if (CMD_VLD && cmd_rdy)  rcnt <= '0;
      else if (XRAM_DAT_VLD)   rcnt <= rcnt + 1'b1;
      if (XRAM_DAT_VLD && ((XRAM_DAT_LST != exp_lst) || f_full)) err <= 1'b1;
    end
  end

  eeg_xram_rd_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (XRAM_DAT_VLD),
    .wdat  ({exp_lst, XRAM_DAT_DAT}),
    .pop   (out_hs),
    .rdat  (f_rdat),
    .full  (f_full),
    .empty (f_empty)
  );

endmodule

// File: tb/tb_eeg_xram_rd_agent.sv
// Directed bench for eeg_xram_rd_agent with a 1-cycle-latency XRAM responder model.
module tb_eeg_xram_rd_agent;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        CMD_VLD, CMD_RDY;
  logic [11:0] CMD_ADD, CMD_STP, CMD_LEN;
  logic        XRAM_ADD_VLD, XRAM_ADD_LST, XRAM_ADD_RDY;
  logic [11:0] XRAM_ADD_ADD;
  logic        XRAM_DAT_VLD, XRAM_DAT_LST, XRAM_DAT_RDY;
  logic [7:0]  XRAM_DAT_DAT;
  logic        OUT_VLD, OUT_RDY, OUT_LST;
  logic [7:0]  OUT_DAT;
  logic        BUSY, DONE, ERR;

  always #5 clk = ~clk;

  eeg_xram_rd_agent #(.XRAM_ADD_AW(12), .XRAM_DAT_DW(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_ADD(CMD_ADD), .CMD_STP(CMD_STP), .CMD_LEN(CMD_LEN),
    .XRAM_ADD_VLD(XRAM_ADD_VLD), .XRAM_ADD_LST(XRAM_ADD_LST), .XRAM_ADD_RDY(XRAM_ADD_RDY),
    .XRAM_ADD_ADD(XRAM_ADD_ADD), .XRAM_DAT_VLD(XRAM_DAT_VLD), .XRAM_DAT_LST(XRAM_DAT_LST),
    .XRAM_DAT_RDY(XRAM_DAT_RDY), .XRAM_DAT_DAT(XRAM_DAT_DAT),
    .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .OUT_LST(OUT_LST), .OUT_DAT(OUT_DAT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  int rbeat = 0, bad_beat = -1, rdy_mode = 0, rdy_while_busy = 0;
  bit add_rnd = 0, last_add_vld = 0;
  bit pv = 0, pl = 0;
  logic [7:0] pd = '0;
  logic [11:0] a_q[$];
  bit          al_q[$];
  int          ac_q[$];
  logic [7:0]  d_q[$];
  bit          dl_q[$];
  int          oc_q[$];

  function automatic logic [7:0] memf(input logic [11:0] a);
    logic [11:0] t;
    t = a * 12'd13 + 12'd7;
    return t[7:0] ^ {4'h0, a[11:8]};
  endfunction

  // One clock: drive inputs at the falling edge, observe what the next rising edge will see.
  task automatic cyc();
    XRAM_DAT_VLD = pv; XRAM_DAT_DAT = pd; XRAM_DAT_LST = pl;
    XRAM_ADD_RDY = add_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    OUT_RDY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    last_add_vld = XRAM_ADD_VLD;
    if (CMD_VLD && CMD_RDY) begin acc_cnt++; acc_cyc = cyc_n; end
    if (CMD_RDY && BUSY) rdy_while_busy++;
    if (XRAM_ADD_VLD && XRAM_ADD_RDY) begin
      a_q.push_back(XRAM_ADD_ADD); al_q.push_back(XRAM_ADD_LST); ac_q.push_back(cyc_n);
      pv = 1'b1; pd = memf(XRAM_ADD_ADD); pl = XRAM_ADD_LST | (rbeat == bad_beat);
      rbeat++;
    end else pv = 1'b0;
    if (OUT_VLD && OUT_RDY) begin
      d_q.push_back(OUT_DAT); dl_q.push_back(OUT_LST); oc_q.push_back(cyc_n);
    end
    if (DONE) begin done_cnt++; done_cyc = cyc_n; end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic issue_cmd(input logic [11:0] b, input logic [11:0] s, input logic [11:0] l,
                           output bit ok);
    int n0;
    a_q.delete(); al_q.delete(); ac_q.delete(); d_q.delete(); dl_q.delete(); oc_q.delete();
    rbeat = 0; n0 = acc_cnt;
    CMD_ADD = b; CMD_STP = s; CMD_LEN = l; CMD_VLD = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == n0; i++) cyc();
    CMD_VLD = 1'b0;
    ok = (acc_cnt != n0);
  endtask

  task automatic run_done(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt < target; i++) cyc();
    ok = (done_cnt >= target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; CMD_VLD = 0; CMD_ADD = '0; CMD_STP = '0; CMD_LEN = '0;
    XRAM_ADD_RDY = 1; XRAM_DAT_VLD = 0; XRAM_DAT_LST = 0; XRAM_DAT_DAT = '0; OUT_RDY = 0;
    @(negedge clk); @(negedge clk); #1;
    n_chk++; if (CMD_RDY !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_rdy got %b exp 1", CMD_RDY); end
    n_chk++; if (XRAM_DAT_RDY !== 1'b1) begin n_fail++; $display("FAIL rst_dat_rdy got %b exp 1", XRAM_DAT_RDY); end
    n_chk++; if ({XRAM_ADD_VLD, XRAM_ADD_LST, XRAM_ADD_ADD} !== 14'h0) begin n_fail++; $display("FAIL rst_add got %h exp 0", {XRAM_ADD_VLD, XRAM_ADD_LST, XRAM_ADD_ADD}); end
    n_chk++; if ({OUT_VLD, OUT_LST, OUT_DAT} !== 10'h0) begin n_fail++; $display("FAIL rst_out got %h exp 0", {OUT_VLD, OUT_LST, OUT_DAT}); end
    n_chk++; if ({BUSY, DONE, ERR} !== 3'b000) begin n_fail++; $display("FAIL rst_status got %b exp 000", {BUSY, DONE, ERR}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    rdy_mode = 0; add_rnd = 0;
    issue_cmd(12'h010, 12'd1, 12'd3, ok1);
    run_done(done_cnt + 1, 50, ok2);
    n_chk++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL basic_timeout got acc=%0b done=%0b exp 1/1", ok1, ok2); end
    n_chk++; if (a_q.size() != 4 || d_q.size() != 4) begin n_fail++; $display("FAIL basic_count got %0d/%0d exp 4/4", a_q.size(), d_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size() && i < d_q.size(); i++) begin
      n_chk++; if (a_q[i] !== 12'(12'h010 + i) || al_q[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_add[%0d] got %h/%b exp %h/%b", i, a_q[i], al_q[i], 12'(12'h010 + i), (i == 3)); end
      n_chk++; if (d_q[i] !== memf(12'(12'h010 + i)) || dl_q[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_out[%0d] got %h/%b exp %h/%b", i, d_q[i], dl_q[i], memf(12'(12'h010 + i)), (i == 3)); end
    end
    if (ac_q.size() > 0 && oc_q.size() == 4) begin
      n_chk++; if (ac_q[0] != acc_cyc + 1 || oc_q[0] != acc_cyc + 3) begin n_fail++; $display("FAIL basic_latency got add@+%0d out@+%0d exp +1/+3", ac_q[0] - acc_cyc, oc_q[0] - acc_cyc); end
      n_chk++; if (oc_q[3] != oc_q[0] + 3 || done_cyc != oc_q[3]) begin n_fail++; $display("FAIL basic_rate got span=%0d done@%0d exp 3 and %0d", oc_q[3] - oc_q[0], done_cyc, oc_q[3]); end
    end
    cyc(); #1;
    n_chk++; if (CMD_RDY !== 1'b1 || BUSY !== 1'b0 || ERR !== 1'b0) begin n_fail++; $display("FAIL basic_idle got rdy=%b busy=%b err=%b exp 1/0/0", CMD_RDY, BUSY, ERR); end
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    issue_cmd(12'hFFE, 12'd1, 12'd3, ok1);
    run_done(done_cnt + 1, 50, ok2);
    n_chk++; if (!(ok1 && ok2) || a_q.size() != 4 || d_q.size() != 4) begin n_fail++; $display("FAIL wrap_count got adds=%0d beats=%0d exp 4/4", a_q.size(), d_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size() && i < d_q.size(); i++) begin
      n_chk++; if (a_q[i] !== exp_a[i] || d_q[i] !== memf(exp_a[i])) begin n_fail++; $display("FAIL wrap[%0d] got %h/%h exp %h/%h", i, a_q[i], d_q[i], exp_a[i], memf(exp_a[i])); end
    end
    n_chk++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b exp 0", ERR); end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    int bad = 0;
    rdy_mode = 2;
    issue_cmd(12'h040, 12'd1, 12'd15, ok1);
    for (int i = 0; i < 12; i++) cyc();
    n_chk++; if (a_q.size() != 4 || last_add_vld !== 1'b0 || d_q.size() != 0) begin n_fail++; $display("FAIL bp_stall got adds=%0d vld=%b beats=%0d exp 4/0/0", a_q.size(), last_add_vld, d_q.size()); end
    rdy_mode = 0;
    run_done(done_cnt + 1, 100, ok2);
    n_chk++; if (!(ok1 && ok2) || a_q.size() != 16 || d_q.size() != 16) begin n_fail++; $display("FAIL bp_count got adds=%0d beats=%0d exp 16/16", a_q.size(), d_q.size()); end
    for (int i = 0; i < d_q.size(); i++)
      if (d_q[i] !== memf(12'(12'h040 + i)) || dl_q[i] !== (i == 15)) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_data got %0d bad beats exp 0", bad); end
  endtask

  task automatic test_random();
    bit ok1, ok2, ok3;
    int bad = 0, acc0;
    rdy_mode = 1; add_rnd = 1; rdy_while_busy = 0;
    issue_cmd(12'h000, 12'd3, 12'd100, ok1);
    acc0 = acc_cnt;
    CMD_ADD = 12'h7F0; CMD_STP = 12'd0; CMD_LEN = 12'd0; CMD_VLD = 1'b1;
    run_done(done_cnt + 1, 3000, ok2);
    n_chk++; if (!(ok1 && ok2) || acc_cnt != acc0) begin n_fail++; $display("FAIL rnd_first got done=%0b extra_acc=%0d exp 1/0", ok2, acc_cnt - acc0); end
    for (int i = 0; i < 5 && acc_cnt == acc0; i++) cyc();
    CMD_VLD = 1'b0;
    n_chk++; if (acc_cnt != acc0 + 1 || acc_cyc != done_cyc + 1) begin n_fail++; $display("FAIL rnd_second_acc got acc@%0d exp %0d", acc_cyc, done_cyc + 1); end
    run_done(done_cnt + 1, 200, ok3);
    n_chk++; if (!ok3 || d_q.size() != 102 || rdy_while_busy != 0) begin n_fail++; $display("FAIL rnd_count got beats=%0d rdy_busy=%0d exp 102/0", d_q.size(), rdy_while_busy); end
    for (int i = 0; i < 101 && i < d_q.size(); i++)
      if (d_q[i] !== memf(12'(3 * i)) || dl_q[i] !== (i == 100)) bad++;
    if (d_q.size() == 102 && (d_q[101] !== memf(12'h7F0) || dl_q[101] !== 1'b1)) bad++;
    n_chk++; if (bad != 0 || ERR !== 1'b0) begin n_fail++; $display("FAIL rnd_data got bad=%0d err=%b exp 0/0", bad, ERR); end
    rdy_mode = 0; add_rnd = 0;
  endtask

  task automatic test_lst_err();
    bit ok1, ok2;
    bad_beat = 1;
    issue_cmd(12'h100, 12'd2, 12'd3, ok1);
    run_done(done_cnt + 1, 50, ok2);
    bad_beat = -1;
    n_chk++; if (!(ok1 && ok2) || dl_q.size() != 4) begin n_fail++; $display("FAIL lst_count got %0d beats exp 4", dl_q.size()); end
    else begin
      n_chk++; if ({dl_q[0], dl_q[1], dl_q[2], dl_q[3]} !== 4'b0001) begin n_fail++; $display("FAIL lst_flags got %b exp 0001", {dl_q[0], dl_q[1], dl_q[2], dl_q[3]}); end
    end
    n_chk++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL lst_err got %b exp 1", ERR); end
    issue_cmd(12'h200, 12'd1, 12'd0, ok1);
    run_done(done_cnt + 1, 50, ok2);
    n_chk++; if (ERR !== 1'b1 || d_q.size() != 1) begin n_fail++; $display("FAIL lst_sticky got err=%b beats=%0d exp 1/1", ERR, d_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    int bad = 0;
    issue_cmd(12'h300, 12'd1, 12'd9, ok1);
    for (int i = 0; i < 40 && d_q.size() < 4; i++) cyc();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (OUT_VLD !== 1'b0 || BUSY !== 1'b0 || CMD_RDY !== 1'b1 || ERR !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got vld=%b busy=%b rdy=%b err=%b exp 0/0/1/0", OUT_VLD, BUSY, CMD_RDY, ERR); end
    pv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    d_q.delete();
    for (int i = 0; i < 5; i++) cyc();
    n_chk++; if (d_q.size() != 0) begin n_fail++; $display("FAIL rstmid_stale got %0d beats exp 0", d_q.size()); end
    issue_cmd(12'h400, 12'd5, 12'd5, ok1);
    run_done(done_cnt + 1, 60, ok2);
    for (int i = 0; i < d_q.size(); i++)
      if (d_q[i] !== memf(12'(12'h400 + 5 * i)) || dl_q[i] !== (i == 5)) bad++;
    n_chk++; if (!(ok1 && ok2) || d_q.size() != 6 || bad != 0) begin n_fail++; $display("FAIL rstmid_after got beats=%0d bad=%0d exp 6/0", d_q.size(), bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_random();
    test_lst_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
